alu_serial_tx: RTL and testbench

Bit-serial transmitter for ALU results. It is the outbound counterpart of the ALU serial operand loader.
- On a start request it captures an 8-bit result and optionally the 4-bit flags.
- It shifts them out MSB first, one bit per CLKS_PER_BIT clocks, with a per-bit strobe.
- Wiring ser_out to bit_in and bit_stb to confirm of a loader rebuilds the value in the destination register.
- It sits beside the ALU core and drives one output pin pair.

---
 rtl/alu_serial_tx.sv | 102 ++++++++++
 tb/tb_alu_serial_tx.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/alu_serial_tx.sv
// rtl/alu_serial_tx.sv - bit-serial MSB-first transmitter for ALU result and flags
module alu_serial_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic [3:0] flags_in,
  input  logic       send_flags,
  input  logic       start,
  input  logic       abort,
  output logic       ser_out,
  output logic       bit_stb,
  output logic       busy,
  output logic       done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [7:0] LP_DIV_LAST = 8'(CLKS_PER_BIT - 1);

  state_t      r_state, w_state_nxt;
  logic [11:0] r_shreg, w_shreg_nxt;
  logic [3:0]  r_len, w_len_nxt;
  logic [3:0]  r_bit_idx, w_bit_idx_nxt;
  logic [7:0]  r_div_cnt, w_div_cnt_nxt;
  logic        r_done, w_done_nxt;
  logic        w_stb;

  assign w_stb = (r_state == SHIFT) && (r_div_cnt == LP_DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_len     <= '0;
      r_bit_idx <= '0;
      r_div_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_len     <= w_len_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_div_cnt <= w_div_cnt_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_len_nxt     = r_len;
    w_bit_idx_nxt = r_bit_idx;
    w_div_cnt_nxt = r_div_cnt;
    w_done_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_shreg_nxt   = {data_in, flags_in};
          w_len_nxt     = send_flags ? 4'd12 : 4'd8;
          w_bit_idx_nxt = '0;
          w_div_cnt_nxt = '0;
          w_state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        // abort wins over a coincident last-bit completion
        if (abort) begin
          w_state_nxt   = IDLE;
          w_shreg_nxt   = '0;
          w_bit_idx_nxt = '0;
          w_div_cnt_nxt = '0;
        end else if (w_stb) begin
          if (r_bit_idx == r_len - 4'd1) begin
            w_state_nxt   = IDLE;
            w_done_nxt    = 1'b1;
            w_shreg_nxt   = '0;
            w_bit_idx_nxt = '0;
            w_div_cnt_nxt = '0;
          end else begin
            w_shreg_nxt   = {r_shreg[10:0], 1'b0};
            w_bit_idx_nxt = r_bit_idx + 4'd1;
            w_div_cnt_nxt = '0;
          end
        end else begin
          w_div_cnt_nxt = r_div_cnt + 8'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign ser_out = (r_state == SHIFT) && r_shreg[11];
  assign bit_stb = w_stb;
  assign busy    = (r_state == SHIFT);
  assign done    = r_done;

endmodule

// File: tb/tb_alu_serial_tx.sv
// tb/tb_alu_serial_tx.sv - randomized self-checking bench for alu_serial_tx
module tb_alu_serial_tx;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = '0;
  logic [3:0] flags_in = '0;
  logic       send_flags = 1'b0, start = 1'b0, abort = 1'b0;
  logic       ser_out, bit_stb, busy, done;

  logic [7:0] data_in1 = '0;
  logic [3:0] flags_in1 = '0;
  logic       send_flags1 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
  logic       ser_out1, bit_stb1, busy1, done1;

  int errors = 0;
  int checks = 0;
  logic [7:0] lb_reg = '0;

  always #5 clk = ~clk;

  alu_serial_tx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .flags_in(flags_in),
    .send_flags(send_flags), .start(start), .abort(abort),
    .ser_out(ser_out), .bit_stb(bit_stb), .busy(busy), .done(done)
  );

  alu_serial_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in1), .flags_in(flags_in1),
    .send_flags(send_flags1), .start(start1), .abort(abort1),
    .ser_out(ser_out1), .bit_stb(bit_stb1), .busy(busy1), .done(done1)
  );

  // destination loader: shift in ser_out on every strobe
  always @(posedge clk) if (bit_stb) lb_reg <= {lb_reg[6:0], ser_out};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input logic [3:0] f, input logic sf,
                           input int abort_at, input bit chain);
    bit bits[$];
    int len, total, end_k;
    logic e_busy, e_ser, e_stb, e_done;
    bits = {};
    for (int i = 7; i >= 0; i--) bits.push_back(d[i]);
    if (sf) for (int i = 3; i >= 0; i--) bits.push_back(f[i]);
    len   = bits.size();
    total = len * C;
    end_k = (abort_at > 0) ? abort_at + 2 : total + 1;
    data_in = d; flags_in = f; send_flags = sf; start = 1'b1;
    abort = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    for (int k = 1; k <= end_k; k++) begin
      if (abort_at > 0 && k > abort_at) begin
        start = 1'b0; abort = 1'b0;
      end else if (k <= total) begin
        data_in = 8'($urandom); flags_in = 4'($urandom);
        send_flags = 1'($urandom); start = 1'($urandom_range(0, 1));
        abort = (k == abort_at);
      end else begin
        start = 1'b0; abort = 1'b0;
      end
      @(negedge clk);
      if (abort_at > 0 && k > abort_at) begin
        e_busy = 0; e_ser = 0; e_stb = 0; e_done = 0;
      end else begin
        e_busy = (k <= total);
        e_ser  = (k <= total) ? bits[(k - 1) / C] : 1'b0;
        e_stb  = (k <= total) && ((k - 1) % C == C - 1);
        e_done = (k == total + 1);
      end
      chk("busy", busy, e_busy);
      chk("ser_out", ser_out, e_ser);
      chk("bit_stb", bit_stb, e_stb);
      chk("done", done, e_done);
      if (abort_at == 0 && k == total + 1)
        chk("loopback", lb_reg, sf ? {d[3:0], f} : d);
      if (k < end_k) begin
        @(posedge clk); #1;
      end
    end
    if (!chain) begin
      start = 1'b0; abort = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int ab;
    bit ch;
    logic sfr;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_ser", ser_out, 0);
    chk("rst_stb", bit_stb, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_frame(8'hA5, 4'h0, 1'b0, 0, 1'b0);
    run_frame(8'h3C, 4'b1010, 1'b1, 0, 1'b0);
    run_frame(8'h5E, 4'h3, 1'b0, 0, 1'b1);
    run_frame(8'hA5, 4'h0, 1'b0, 0, 1'b0);
    run_frame(8'hC3, 4'h0, 1'b0, 3 * C, 1'b0);
    run_frame(8'h96, 4'h9, 1'b1, 0, 1'b0);
    run_frame(8'h71, 4'h0, 1'b0, 8 * C, 1'b0);

    for (int n = 0; n < 24; n++) begin
      sfr = 1'($urandom);
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, (sfr ? 12 : 8) * C)) : 0;
      ch  = (ab == 0) && ($urandom_range(0, 2) == 0);
      run_frame(8'($urandom), 4'($urandom), sfr, ab, ch);
    end

    data_in = 8'h96; send_flags = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ser", ser_out, 0);
    chk("arst_stb", bit_stb, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk("arst_no_done", done, 0);
      chk("arst_idle", busy, 0);
    end

    @(posedge clk); #1;
    data_in1 = 8'h81; send_flags1 = 1'b0; start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0; data_in1 = 8'h00;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("c1_busy", busy1, k <= 8);
      chk("c1_stb", bit_stb1, k <= 8);
      chk("c1_ser", ser_out1, (k == 1 || k == 8));
      chk("c1_done", done1, k == 9);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
